rand_prefetch: RTL and testbench
================================

RAND_PREFETCH -- requirements
Module: rand_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, meaning prefetch FIFO entries; SHALL be a power of two, 2..16.
REQ-002 Parameter DISCARD, default 0, meaning number of warm-up words drawn and dropped after reset, 0..255.
REQ-003 CLK  input  1  clock; all state SHALL update on posedge CLK only.
REQ-004 RESET  input  1  reset, synchronous, active-high.
REQ-005 REQ_WRITE  output  1  advance strobe to the random-word source; the source's next word is taken at this edge.
REQ-006 REQ_WRITE_VALID  output  1  client wants a word this cycle.
REQ-007 RESP_READ  input  32  current random word from the source.
REQ-008 RESP_READ_VALID  input  1  source word valid.
REQ-009 DONE  input  1  source ready; no transfer while low.
REQ-010 OUT_DATA  output  32  head-of-FIFO word.
REQ-011 OUT_VALID  output  1  OUT_DATA valid.
REQ-012 OUT_READY  input  1  consumer accepts OUT_DATA.
REQ-013 LEVEL  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-014 Upstream transfer ("take") SHALL occur in a cycle with REQ_WRITE_VALID=1, RESP_READ_VALID=1 and DONE=1; REQ_WRITE SHALL be 1 exactly in take cycles, otherwise 0.
REQ-015 On a take, RESP_READ SHALL be sampled in the same cycle (zero added latency); the source advances on that edge.
REQ-016 State machine SHALL have states WARM, FILL, RUN; reset state SHALL be WARM if DISCARD>0, else FILL.
REQ-017 WARM: REQ_WRITE_VALID=1, each take decrements an 8-bit discard counter and the word is dropped; after the DISCARD-th take, next state FILL.
REQ-018 FILL: REQ_WRITE_VALID=1 while FIFO not full; OUT_VALID=0 regardless of LEVEL; when LEVEL reaches DEPTH, next state RUN.
REQ-019 RUN: REQ_WRITE_VALID=1 iff LEVEL<DEPTH, or LEVEL=DEPTH and a dequeue occurs this cycle; OUT_VALID=1 iff LEVEL>0.
REQ-020 Dequeue SHALL occur when OUT_VALID=1 and OUT_READY=1; OUT_DATA SHALL then advance to the next entry on the following cycle.
REQ-021 Simultaneous take and dequeue SHALL leave LEVEL unchanged; full FIFO with simultaneous dequeue SHALL accept the take.
REQ-022 Take with no dequeue SHALL increment LEVEL; dequeue with no take SHALL decrement LEVEL; LEVEL SHALL never exceed DEPTH nor underflow.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; words SHALL be delivered strictly in take order.
REQ-024 RUN SHALL NOT return to FILL when LEVEL reaches 0; OUT_VALID simply deasserts.
REQ-025 OUT_DATA SHALL be don't-care while OUT_VALID=0; OUT_READY while OUT_VALID=0 SHALL have no effect.

Reset
REQ-026 RESET=1 at a posedge SHALL set LEVEL=0, pointers=0, discard counter=DISCARD, OUT_VALID=0, REQ_WRITE=0, REQ_WRITE_VALID=0 during the reset cycle, state per REQ-016.
REQ-027 Reset mid-operation SHALL drop all FIFO contents and abort WARM/FILL progress; no take SHALL occur in a cycle where RESET=1.
REQ-028 FIFO storage array SHALL NOT require reset.

Configuration
REQ-029 Macro RAND_PREFETCH_CNT_EN defined: output DEQ_COUNT [31:0] SHALL exist, reset to 0, increment by 1 per dequeue, wrap 0xFFFFFFFF->0.
REQ-030 Macro RAND_PREFETCH_CNT_EN undefined: port DEQ_COUNT and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-031 DISCARD=0, DEPTH=4, source words 1,2,3,4,5..., DONE=1, OUT_READY=0 -> 4 takes in cycles 1-4, LEVEL=4, then OUT_VALID=1, OUT_DATA=1, REQ_WRITE=0.
REQ-032 DISCARD=3, same source -> first 3 takes dropped; OUT_DATA sequence starts 4,5,6,7.
REQ-033 RUN, full, OUT_READY held 1 -> one take and one dequeue per cycle, LEVEL stays 4, outputs 1,2,3,... with no gaps.
REQ-034 RUN, DONE=0 for 6 cycles, OUT_READY=1 -> LEVEL drains 4->0, OUT_VALID=0, REQ_WRITE=0; DONE=1 -> refill, state stays RUN.
REQ-035 RESET pulse with LEVEL=3 -> next cycle LEVEL=0, OUT_VALID=0, FILL (or WARM) restarts, old words never delivered.
REQ-036 With RAND_PREFETCH_CNT_EN, 10 dequeues -> DEQ_COUNT=10; preset near 0xFFFFFFFF via dequeues -> wraps to 0.

Source files
------------

// File: rtl/rand_prefetch.sv
// rand_prefetch: prefetches words from a random-word source into a small FIFO
// so a consumer can draw one word per cycle without seeing source latency.
//
// Optional feature: define RAND_PREFETCH_CNT_EN to add the DEQ_COUNT output,
// a 32-bit wrapping count of words handed to the consumer.
//
// Handshakes:
//   upstream   - a word is taken when REQ_WRITE_VALID, RESP_READ_VALID and DONE
//                are all 1 in the same cycle; REQ_WRITE is 1 exactly then, and
//                RESP_READ is captured at that same clock edge.
//   downstream - a word is dequeued when OUT_VALID and OUT_READY are both 1;
//                OUT_DATA is meaningless while OUT_VALID is 0 and OUT_READY
//                is then ignored.
// STATE exposes the controller state (0 = WARM, 1 = FILL, 2 = RUN).
module rand_prefetch #(
   parameter int DEPTH   = 4,
   parameter int DISCARD = 0
) (
   input  logic                     CLK,
   input  logic                     RESET,
   output logic                     REQ_WRITE,
   output logic                     REQ_WRITE_VALID,
   input  logic [31:0]              RESP_READ,
   input  logic                     RESP_READ_VALID,
   input  logic                     DONE,
   output logic [31:0]              OUT_DATA,
   output logic                     OUT_VALID,
   input  logic                     OUT_READY,
   output logic [$clog2(DEPTH):0]   LEVEL,
   output logic [1:0]               STATE
`ifdef RAND_PREFETCH_CNT_EN
   ,
   output logic [31:0]              DEQ_COUNT
`endif
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] ST_WARM = 2'd0;
   localparam logic [1:0] ST_FILL = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   localparam logic [AW:0] FULL_LVL  = DEPTH[AW:0];
   localparam logic [7:0]  DISC_INIT = DISCARD[7:0];
   localparam logic [1:0]  ST_RESET  = (DISCARD > 0) ? ST_WARM : ST_FILL;

   logic [1:0]    state;
   logic [AW:0]   level;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [7:0]    disc_cnt;
   logic [31:0]   mem [DEPTH];

   logic full;
   logic out_valid;
   logic deq;
   logic want;
   logic take;
   logic store;

   assign full      = (level == FULL_LVL);
   // Output is only offered once the FIFO has been primed; never during reset.
   assign out_valid = !RESET && (state == ST_RUN) && (level != '0);
   assign deq       = out_valid && OUT_READY;
   assign take      = want && RESP_READ_VALID && DONE;
   // Warm-up words are drawn from the source but never stored.
   assign store     = take && (state != ST_WARM);

   // Decide whether a source word is wanted this cycle.
   always_comb begin
      want = 1'b0;
      if (!RESET) begin
         case (state)
            ST_WARM: want = 1'b1;
            ST_FILL: want = !full;
            ST_RUN:  want = !full || deq;
            default: want = 1'b0;
         endcase
      end
   end

   // Controller state, occupancy, pointers and warm-up counter.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state    <= ST_RESET;
         level    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         disc_cnt <= DISC_INIT;
      end else begin
         if (store) wr_ptr <= wr_ptr + AW'(1);
         if (deq)   rd_ptr <= rd_ptr + AW'(1);

         if (store && !deq)      level <= level + 1'b1;
         else if (!store && deq) level <= level - 1'b1;

         case (state)
            ST_WARM: begin
               if (take) begin
                  disc_cnt <= disc_cnt - 1'b1;
                  if (disc_cnt == 8'd1) state <= ST_FILL;
               end
            end
            ST_FILL: begin
               // Nothing leaves while filling, so the last free slot taken means full.
               if (store && (level == FULL_LVL - 1'b1)) state <= ST_RUN;
            end
            ST_RUN: begin
               // Stays here even when drained; OUT_VALID simply drops.
               state <= ST_RUN;
            end
            default: state <= ST_RESET;
         endcase
      end
   end

   // FIFO storage; contents are irrelevant until written, so no reset.
   always_ff @(posedge CLK) begin
      if (store) mem[wr_ptr] <= RESP_READ;
   end

`ifdef RAND_PREFETCH_CNT_EN
   // Running count of dequeued words, wrapping at 2^32.
   always_ff @(posedge CLK) begin
      if (RESET)    DEQ_COUNT <= '0;
      else if (deq) DEQ_COUNT <= DEQ_COUNT + 32'd1;
   end
`endif

   assign REQ_WRITE       = take;
   assign REQ_WRITE_VALID = want;
   assign OUT_VALID       = out_valid;
   assign OUT_DATA        = mem[rd_ptr];
   assign LEVEL           = level;
   assign STATE           = state;

endmodule

// File: tb/tb_rand_prefetch.sv
// Bench for rand_prefetch. Two instances share control inputs: dut_a
// (DEPTH=4, DISCARD=3) is tracked every cycle by a queue-based reference
// model; dut_b (DEPTH=4, DISCARD=0) is checked with directed expectations.
module tb_rand_prefetch;

   localparam int DEPTH  = 4;
   localparam int DISC_A = 3;

   logic        clk;
   logic        reset;
   logic        done;
   logic        rv;
   logic        ready;
   bit          src_rand;

   logic [31:0] resp_a = 32'd1;
   logic [31:0] resp_b = 32'd1;

   logic        a_req_write, a_req_write_valid, a_out_valid;
   logic [31:0] a_out_data;
   logic [2:0]  a_level;
   logic [1:0]  a_state;
   logic        b_req_write, b_req_write_valid, b_out_valid;
   logic [31:0] b_out_data;
   logic [2:0]  b_level;
   logic [1:0]  b_state;
`ifdef RAND_PREFETCH_CNT_EN
   logic [31:0] a_deq_count;
   logic [31:0] b_deq_count;
`endif

   int checks   = 0;
   int failures = 0;

   rand_prefetch #(.DEPTH(DEPTH), .DISCARD(DISC_A)) dut_a (
      .CLK(clk), .RESET(reset),
      .REQ_WRITE(a_req_write), .REQ_WRITE_VALID(a_req_write_valid),
      .RESP_READ(resp_a), .RESP_READ_VALID(rv), .DONE(done),
      .OUT_DATA(a_out_data), .OUT_VALID(a_out_valid), .OUT_READY(ready),
      .LEVEL(a_level), .STATE(a_state)
`ifdef RAND_PREFETCH_CNT_EN
      , .DEQ_COUNT(a_deq_count)
`endif
   );

   rand_prefetch #(.DEPTH(DEPTH), .DISCARD(0)) dut_b (
      .CLK(clk), .RESET(reset),
      .REQ_WRITE(b_req_write), .REQ_WRITE_VALID(b_req_write_valid),
      .RESP_READ(resp_b), .RESP_READ_VALID(rv), .DONE(done),
      .OUT_DATA(b_out_data), .OUT_VALID(b_out_valid), .OUT_READY(ready),
      .LEVEL(b_level), .STATE(b_state)
`ifdef RAND_PREFETCH_CNT_EN
      , .DEQ_COUNT(b_deq_count)
`endif
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Random-word sources: advance on each REQ_WRITE edge.
   always @(posedge clk) begin
      if (a_req_write) resp_a <= src_rand ? $urandom : resp_a + 32'd1;
      if (b_req_write) resp_b <= src_rand ? $urandom : resp_b + 32'd1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model for dut_a: a word queue plus a phase, updated from the
   // prefetcher's rules each cycle and compared on the falling edge.
   logic [31:0] mq[$];
   int          m_phase;   // 0 warm-up, 1 priming, 2 serving
   int          m_disc;
   bit          m_valid = 1'b0;
   logic [31:0] m_deqs;

   always @(negedge clk) begin : model
      bit e_ov;
      bit e_deq;
      bit e_rwv;
      bit e_take;
      if (m_valid) begin
         e_ov  = !reset && (m_phase == 2) && (mq.size() > 0);
         e_deq = e_ov && ready;
         if (reset)             e_rwv = 1'b0;
         else if (m_phase == 0) e_rwv = 1'b1;
         else if (m_phase == 1) e_rwv = (mq.size() < DEPTH);
         else                   e_rwv = (mq.size() < DEPTH) || e_deq;
         e_take = e_rwv && rv && done;

         chk("a_level", a_level, mq.size());
         chk("a_req_write_valid", a_req_write_valid, e_rwv);
         chk("a_req_write", a_req_write, e_take);
         chk("a_out_valid", a_out_valid, e_ov);
         if (e_ov) chk("a_out_data", a_out_data, mq[0]);
`ifdef RAND_PREFETCH_CNT_EN
         chk("a_deq_count", a_deq_count, m_deqs);
`endif
         if (!reset) begin
            if (e_deq) begin
               void'(mq.pop_front());
               m_deqs = m_deqs + 32'd1;
            end
            if (e_take) begin
               if (m_phase == 0) begin
                  m_disc--;
                  if (m_disc == 0) m_phase = 1;
               end else begin
                  mq.push_back(resp_a);
                  if (m_phase == 1 && mq.size() == DEPTH) m_phase = 2;
               end
            end
         end
      end
      if (reset) begin
         mq.delete();
         m_phase = (DISC_A > 0) ? 0 : 1;
         m_disc  = DISC_A;
         m_deqs  = '0;
         m_valid = 1'b1;
      end
   end

   // Directed and random stimulus.
   initial begin
      logic [31:0] first_word;
      reset = 1'b1; done = 1'b1; rv = 1'b1; ready = 1'b0; src_rand = 1'b0;
      step(); step();

      // Reset state.
      @(negedge clk);
      chk("b_rst_level", b_level, 0);
      chk("b_rst_out_valid", b_out_valid, 0);
      chk("b_rst_req_write_valid", b_req_write_valid, 0);
      chk("b_rst_req_write", b_req_write, 0);
      chk("b_rst_state", b_state, 2'd1);
      chk("a_rst_state", a_state, 2'd0);

      // Priming with no discard: takes in cycles 1-4, then full and offering word 1.
      step(); reset = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         chk("b_fill_take", b_req_write, 1);
         chk("b_fill_out_valid", b_out_valid, 0);
         step();
      end
      @(negedge clk);
      chk("b_full_level", b_level, 4);
      chk("b_full_out_valid", b_out_valid, 1);
      chk("b_full_out_data", b_out_data, 1);
      chk("b_full_req_write", b_req_write, 0);
      chk("b_full_state", b_state, 2'd2);

      // With three words discarded the first delivered word is 4.
      step(); step(); step();
      @(negedge clk);
      chk("a_first_out_valid", a_out_valid, 1);
      chk("a_first_out_data", a_out_data, 4);

      // Consumer always ready: one word in and one out per cycle, no gaps.
      step(); ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("b_stream_data", b_out_data, 32'(1 + i));
         chk("b_stream_level", b_level, 4);
         chk("b_stream_take", b_req_write, 1);
         chk("a_stream_data", a_out_data, 32'(4 + i));
         step();
      end

      // Source stalls: the FIFO drains, then refills without leaving RUN.
      done = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("b_drain_level", b_level, (k < 4) ? 32'(4 - k) : 32'd0);
         chk("b_drain_req_write", b_req_write, 0);
         if (k >= 4) chk("b_drain_out_valid", b_out_valid, 0);
         step();
      end
      done = 1'b1;
      @(negedge clk);
      chk("b_refill_take", b_req_write, 1);
      chk("b_refill_state", b_state, 2'd2);
      step();
      @(negedge clk);
      chk("b_refill_out_valid", b_out_valid, 1);
      chk("b_refill_level", b_level, 1);
      chk("b_refill_state2", b_state, 2'd2);

      // Random traffic with occasional resets; dut_a tracked by the model.
      src_rand = 1'b1;
      for (int n = 0; n < 400; n++) begin
         step();
         reset = ($urandom_range(0, 39) == 0);
         done  = ($urandom_range(0, 3) != 0);
         rv    = ($urandom_range(0, 4) != 0);
         ready = ($urandom_range(0, 2) != 0);
      end

      // Reset with three words buffered: old words must never appear.
      step();
      src_rand = 1'b0; reset = 1'b1; done = 1'b1; rv = 1'b1; ready = 1'b0;
      step(); reset = 1'b0;
      for (int i = 0; i < 5; i++) step();
      @(negedge clk);
      chk("b_pre_level", b_level, 4);
      step(); ready = 1'b1; done = 1'b0;
      @(negedge clk);
      chk("b_pre_deq_valid", b_out_valid, 1);
      step(); ready = 1'b0;
      @(negedge clk);
      chk("b_pre_level3", b_level, 3);
      step(); reset = 1'b1;
      @(negedge clk);
      chk("b_rst_cycle_rwv", b_req_write_valid, 0);
      chk("b_rst_cycle_take", b_req_write, 0);
      chk("b_rst_cycle_out_valid", b_out_valid, 0);
      step(); reset = 1'b0; done = 1'b1;
      @(negedge clk);
      chk("b_post_level", b_level, 0);
      chk("b_post_out_valid", b_out_valid, 0);
      chk("b_post_state", b_state, 2'd1);
      chk("b_post_take", b_req_write, 1);
      first_word = resp_b;
      for (int i = 0; i < 4; i++) step();
      @(negedge clk);
      chk("b_post_out_valid2", b_out_valid, 1);
      chk("b_post_out_data", b_out_data, first_word);
      chk("b_post_state2", b_state, 2'd2);

`ifdef RAND_PREFETCH_CNT_EN
      // Ten dequeues after a fresh reset.
      step(); reset = 1'b1;
      step(); reset = 1'b0;
      for (int i = 0; i < 4; i++) step();
      ready = 1'b1;
      for (int i = 0; i < 10; i++) step();
      ready = 1'b0;
      @(negedge clk);
      chk("b_deq_count", b_deq_count, 10);
`endif

      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
